multi_channel_sensor_sequencer: RTL and testbench

- Parametrised successor to the single-sensor adapter datapath: it drives up to NUM_CHANNELS sensors through one shared ADC.
- One start command scans every channel selected in a mask, in ascending channel order.
- For each channel it takes 2^avg_log2 conversions, averages them, and emits one result per channel on a valid/ready stream.
- It sits between the 14443-4 command adapter (command and result side) and the analogue sensor/ADC pins.

---
 rtl/multi_channel_sensor_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_multi_channel_sensor_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_sensor_sequencer.sv
// Scans the sensors selected in a mask through one shared ADC, averages 2^avg_log2
// conversions per channel and streams one result per channel over valid/ready.
module multi_channel_sensor_sequencer #(
    parameter int NUM_CHANNELS   = 4,
    parameter int ADC_WIDTH      = 16,
    parameter int CONFIG_WIDTH   = 3,
    parameter int MAX_AVG_LOG2   = 4,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int AVG_W = $clog2(MAX_AVG_LOG2 + 1),
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    input  logic [AVG_W-1:0]        avg_log2,
    input  logic [CONFIG_WIDTH-1:0] config_in,
    output logic                    busy,
    output logic                    done,
    output logic [CONFIG_WIDTH-1:0] sens_config,
    output logic [NUM_CHANNELS-1:0] sens_enable,
    output logic [NUM_CHANNELS-1:0] sens_read,
    output logic                    adc_enable,
    output logic                    adc_read,
    input  logic                    adc_conversion_complete,
    input  logic [ADC_WIDTH-1:0]    adc_value,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [CH_W-1:0]         result_channel,
    output logic [ADC_WIDTH-1:0]    result_value,
    output logic                    result_timeout
);

    localparam int ACC_W = ADC_WIDTH + MAX_AVG_LOG2;
    localparam int SMP_W = MAX_AVG_LOG2 + 1;
    localparam int STL_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, READ, WAIT, RESULT, NEXT, DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [NUM_CHANNELS-1:0] mask_reg, mask_next;
    logic [AVG_W-1:0]        avg_reg, avg_next;
    logic [CONFIG_WIDTH-1:0] config_reg, config_next;
    logic [CH_W-1:0]         ch_reg, ch_next;
    logic [ACC_W-1:0]        acc_reg, acc_next;
    logic                    tmo_flag_reg, tmo_flag_next;
    logic [STL_W-1:0]        settle_cnt_reg, settle_cnt_next;
    logic [TMO_W-1:0]        tmo_cnt_reg, tmo_cnt_next;
    logic [SMP_W-1:0]        sample_cnt_reg, sample_cnt_next;
    logic                    adc_en_reg, adc_en_next;

    logic [NUM_CHANNELS-1:0] lower_seen;
    logic [NUM_CHANNELS-1:0] low_onehot;
    logic [NUM_CHANNELS-1:0] chan_onehot;
    logic [CH_W-1:0]         low_idx;
    logic [SMP_W-1:0]        sample_inc;
    logic [SMP_W-1:0]        sample_target;
    logic                    tmo_hit;
    logic                    chan_active;
    logic [ADC_WIDTH-1:0]    avg_value;

    // Lowest set bit of the remaining mask, and decode of the active channel
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            if (gi == 0) begin : g_first
                assign lower_seen[gi] = 1'b0;
            end else begin : g_rest
                assign lower_seen[gi] = lower_seen[gi-1] | mask_reg[gi-1];
            end
            assign low_onehot[gi]  = mask_reg[gi] & ~lower_seen[gi];
            assign chan_onehot[gi] = (ch_reg == CH_W'(gi));
        end
    endgenerate

    always_comb begin
        low_idx = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (low_onehot[i]) low_idx = low_idx | CH_W'(i);
        end
    end

    assign sample_inc    = sample_cnt_reg + SMP_W'(1);
    assign sample_target = SMP_W'(1) << avg_reg;
    assign tmo_hit       = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
    assign avg_value     = ADC_WIDTH'(acc_reg >> avg_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            mask_reg       <= '0;
            avg_reg        <= '0;
            config_reg     <= '0;
            ch_reg         <= '0;
            acc_reg        <= '0;
            tmo_flag_reg   <= 1'b0;
            settle_cnt_reg <= '0;
            tmo_cnt_reg    <= '0;
            sample_cnt_reg <= '0;
            adc_en_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mask_reg       <= mask_next;
            avg_reg        <= avg_next;
            config_reg     <= config_next;
            ch_reg         <= ch_next;
            acc_reg        <= acc_next;
            tmo_flag_reg   <= tmo_flag_next;
            settle_cnt_reg <= settle_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            sample_cnt_reg <= sample_cnt_next;
            adc_en_reg     <= adc_en_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        mask_next       = mask_reg;
        avg_next        = avg_reg;
        config_next     = config_reg;
        ch_next         = ch_reg;
        acc_next        = acc_reg;
        tmo_flag_next   = tmo_flag_reg;
        settle_cnt_next = settle_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        sample_cnt_next = sample_cnt_reg;
        adc_en_next     = adc_en_reg;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    mask_next       = channel_mask;
                    config_next     = config_in;
                    avg_next        = (avg_log2 > AVG_W'(MAX_AVG_LOG2)) ? AVG_W'(MAX_AVG_LOG2) : avg_log2;
                    acc_next        = '0;
                    tmo_flag_next   = 1'b0;
                    sample_cnt_next = '0;
                    state_next      = (channel_mask == '0) ? DONE : NEXT;
                end
            end
            NEXT: begin
                if (mask_reg == '0) begin
                    state_next = DONE;
                end else begin
                    ch_next         = low_idx;
                    mask_next       = mask_reg & ~low_onehot;
                    settle_cnt_next = '0;
                    sample_cnt_next = '0;
                    adc_en_next     = 1'b1;
                    state_next      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_reg == STL_W'(SETTLE_CYCLES - 1)) begin
                    state_next = READ;
                end else begin
                    settle_cnt_next = settle_cnt_reg + STL_W'(1);
                end
            end
            READ: begin
                tmo_cnt_next = '0;
                state_next   = WAIT;
            end
            WAIT: begin
                // A missing conversion contributes zero but still counts as a sample
                if (adc_conversion_complete) begin
                    acc_next = acc_reg + ACC_W'(adc_value);
                end else if (tmo_hit) begin
                    tmo_flag_next = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
                if (adc_conversion_complete || tmo_hit) begin
                    sample_cnt_next = sample_inc;
                    state_next      = (sample_inc == sample_target) ? RESULT : READ;
                end
            end
            RESULT: begin
                if (result_ready) begin
                    acc_next      = '0;
                    tmo_flag_next = 1'b0;
                    state_next    = NEXT;
                end
            end
            DONE: begin
                adc_en_next = 1'b0;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort drops everything, including a pending result; the config is kept
        if (abort && state_reg != IDLE) begin
            state_next      = IDLE;
            mask_next       = '0;
            acc_next        = '0;
            tmo_flag_next   = 1'b0;
            settle_cnt_next = '0;
            tmo_cnt_next    = '0;
            sample_cnt_next = '0;
            adc_en_next     = 1'b0;
        end
    end

    assign chan_active    = (state_reg == SETTLE) || (state_reg == READ) ||
                            (state_reg == WAIT)   || (state_reg == RESULT);
    assign sens_enable    = chan_active ? chan_onehot : '0;
    assign sens_read      = (state_reg == READ) ? chan_onehot : '0;
    assign adc_read       = (state_reg == READ);
    assign adc_enable     = adc_en_reg;
    assign busy           = (state_reg != IDLE);
    assign done           = (state_reg == DONE);
    assign sens_config    = config_reg;
    assign result_valid   = (state_reg == RESULT);
    assign result_channel = result_valid ? ch_reg : '0;
    assign result_value   = result_valid ? avg_value : '0;
    assign result_timeout = result_valid & tmo_flag_reg;

endmodule

// File: tb/tb_multi_channel_sensor_sequencer.sv
// Scoreboard bench: the main process issues scans and queues expected results,
// a monitor pops and compares them as the sequencer presents each result.
`timescale 1ns/1ps
module tb_multi_channel_sensor_sequencer;

    localparam int TMO = 4096;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [3:0]  channel_mask;
    logic [2:0]  avg_log2;
    logic [2:0]  config_in;
    logic        busy, done;
    logic [2:0]  sens_config;
    logic [3:0]  sens_enable, sens_read;
    logic        adc_enable, adc_read;
    logic        adc_conversion_complete;
    logic [15:0] adc_value;
    logic        result_valid, result_ready;
    logic [1:0]  result_channel;
    logic [15:0] result_value;
    logic        result_timeout;

    multi_channel_sensor_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .channel_mask(channel_mask), .avg_log2(avg_log2), .config_in(config_in),
        .busy(busy), .done(done), .sens_config(sens_config),
        .sens_enable(sens_enable), .sens_read(sens_read),
        .adc_enable(adc_enable), .adc_read(adc_read),
        .adc_conversion_complete(adc_conversion_complete), .adc_value(adc_value),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_channel(result_channel), .result_value(result_value),
        .result_timeout(result_timeout)
    );

    always #5 clk = ~clk;

    typedef struct { int lat; logic [15:0] val; } adc_rsp_t;
    typedef struct packed { logic [1:0] ch; logic [15:0] val; logic tmo; } exp_t;

    adc_rsp_t adc_q[$];
    exp_t     exp_q[$];
    int       read_cyc[$];

    int tests = 0, fails = 0;
    int cyc = 0;
    int start_edge = 0, rise_cyc = 0, hs_cyc = 0, done_cyc = 0;
    int result_cnt = 0, done_cnt = 0, read_cnt = 0, viol_cnt = 0;
    int stall_cycles = 0;
    int flush_req = 0;
    bit forbid_ch2 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_no_cfg();
        return 64'({busy, done, sens_enable, sens_read, adc_enable, adc_read,
                    result_valid, result_channel, result_value, result_timeout});
    endfunction

    function automatic int cnt_of(input int which);
        case (which)
            0:       return result_cnt;
            1:       return done_cnt;
            default: return read_cnt;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int target, input int budget);
        int k;
        k = 0;
        while (cnt_of(which) < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(cnt_of(which) >= target), 64'd1);
    endtask

    task automatic do_start(input logic [3:0] m, input logic [2:0] a, input logic [2:0] c);
        @(posedge clk); #1;
        channel_mask = m; avg_log2 = a; config_in = c; start = 1'b1;
        @(negedge clk);
        start_edge = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_adc(input int lat, input logic [15:0] val);
        adc_rsp_t r;
        r.lat = lat; r.val = val;
        adc_q.push_back(r);
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic [15:0] val, input logic tmo);
        exp_t e;
        e.ch = ch; e.val = val; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    // ADC model: answers L cycles after the read strobe; a negative latency never answers
    initial begin
        int pend;
        int fseen;
        logic [15:0] pval;
        adc_rsp_t r;
        pend = 0; fseen = 0; pval = '0;
        adc_conversion_complete = 1'b0;
        adc_value = 16'hdead;
        forever begin
            @(negedge clk);
            adc_conversion_complete = 1'b0;
            adc_value = 16'hdead;
            if (flush_req != fseen) begin
                fseen = flush_req;
                pend = 0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    adc_conversion_complete = 1'b1;
                    adc_value = pval;
                end
            end
            if (adc_read) begin
                read_cnt++;
                read_cyc.push_back(cyc);
                pend = 0;
                if (adc_q.size() > 0) begin
                    r = adc_q.pop_front();
                    if (r.lat > 0) begin
                        pend = r.lat;
                        pval = r.val;
                    end
                end
            end
        end
    end

    // Monitor: compares every presented result with the queue head, drives ready
    initial begin
        int stall;
        bit prev_valid;
        exp_t e;
        stall = 0; prev_valid = 0;
        result_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!$onehot0(sens_enable) || (forbid_ch2 && sens_enable[2])) viol_cnt++;
            if (result_valid) begin
                if (!prev_valid) rise_cyc = cyc;
                check("result_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() == 0) begin
                    result_ready = 1'b1;
                end else begin
                    e = exp_q[0];
                    check("result_fields", 64'({result_channel, result_value, result_timeout}), 64'(e));
                    if (stall >= stall_cycles) begin
                        result_ready = 1'b1;
                        void'(exp_q.pop_front());
                        hs_cyc = cyc;
                        result_cnt++;
                        stall = 0;
                        $display("[TB] result ch=%0d value=0x%04h timeout=%0d at cycle %0d",
                                 result_channel, result_value, result_timeout, cyc);
                    end else begin
                        result_ready = 1'b0;
                        stall++;
                    end
                end
            end else begin
                result_ready = 1'b0;
                stall = 0;
            end
            prev_valid = result_valid;
        end
    end

    initial begin
        int base_r, base_d, base_rd, base_v, rb;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        channel_mask = '0; avg_log2 = '0; config_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs_no_cfg(), 64'd0);
        check("reset_config", 64'(sens_config), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single channel, pass-through, exact latency
        base_r = result_cnt; base_d = done_cnt; base_rd = read_cnt;
        push_adc(5, 16'h1234);
        push_exp(2'd0, 16'h1234, 1'b0);
        do_start(4'b0001, 3'd0, 3'd5);
        wait_for("t1_result", 0, base_r + 1, 200);
        check("t1_latency", 64'(rise_cyc - start_edge), 64'd23);
        wait_for("t1_done", 1, base_d + 1, 50);
        check("t1_done_delay", 64'(done_cyc - (hs_cyc + 1)), 64'd1);
        check("t1_reads", 64'(read_cnt - base_rd), 64'd1);
        @(negedge clk);
        check("t1_config_held", 64'(sens_config), 64'd5);
        check("t1_idle_after", 64'({busy, adc_enable, sens_enable}), 64'd0);

        // Averaging of four samples on channel 2
        base_r = result_cnt; base_rd = read_cnt;
        push_adc(3, 16'd100); push_adc(3, 16'd101); push_adc(3, 16'd102); push_adc(3, 16'd105);
        push_exp(2'd2, 16'd102, 1'b0);
        do_start(4'b0100, 3'd2, 3'd1);
        wait_for("t2_result", 0, base_r + 1, 400);
        check("t2_reads", 64'(read_cnt - base_rd), 64'd4);
        repeat (5) @(negedge clk);

        // Three channels with backpressure, plus an ignored start while busy
        base_r = result_cnt; base_d = done_cnt; base_v = viol_cnt;
        stall_cycles = 10; forbid_ch2 = 1;
        push_adc(3, 16'h0111); push_adc(3, 16'h0222); push_adc(3, 16'h0333);
        push_exp(2'd0, 16'h0111, 1'b0); push_exp(2'd1, 16'h0222, 1'b0); push_exp(2'd3, 16'h0333, 1'b0);
        do_start(4'b1011, 3'd0, 3'd2);
        repeat (5) @(posedge clk);
        do_start(4'b0100, 3'd0, 3'd7);
        wait_for("t3_results", 0, base_r + 3, 600);
        wait_for("t3_done", 1, base_d + 1, 50);
        repeat (30) @(negedge clk);
        check("t3_single_done", 64'(done_cnt - base_d), 64'd1);
        check("t3_onehot_no_ch2", 64'(viol_cnt - base_v), 64'd0);
        check("t3_config", 64'(sens_config), 64'd2);
        stall_cycles = 0; forbid_ch2 = 0;

        // Timeout on the first of two samples
        base_r = result_cnt; rb = read_cyc.size();
        push_adc(-1, 16'h0); push_adc(4, 16'd200);
        push_exp(2'd0, 16'd100, 1'b1);
        do_start(4'b0001, 3'd1, 3'd0);
        wait_for("t4_result", 0, base_r + 1, TMO + 500);
        check("t4_wait_len", 64'(read_cyc[rb+1] - read_cyc[rb]), 64'(TMO + 1));
        repeat (5) @(negedge clk);

        // Abort during the second sample of channel 1
        base_r = result_cnt; base_d = done_cnt; base_rd = read_cnt;
        push_adc(2, 16'd10); push_adc(2, 16'd20); push_adc(2, 16'd30); push_adc(-1, 16'h0);
        push_exp(2'd0, 16'd15, 1'b0);
        do_start(4'b0011, 3'd1, 3'd3);
        wait_for("t5_reads", 2, base_rd + 4, 400);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("t5_abort_outputs", outs_no_cfg(), 64'd0);
        check("t5_abort_config", 64'(sens_config), 64'd3);
        repeat (20) @(negedge clk);
        check("t5_no_done", 64'(done_cnt - base_d), 64'd0);
        check("t5_ch0_result", 64'(result_cnt - base_r), 64'd1);
        adc_q.delete(); flush_req++;
        base_r = result_cnt; base_d = done_cnt;
        push_adc(3, 16'h0055);
        push_exp(2'd1, 16'h0055, 1'b0);
        do_start(4'b0010, 3'd0, 3'd1);
        wait_for("t5_restart_result", 0, base_r + 1, 200);
        wait_for("t5_restart_done", 1, base_d + 1, 50);

        // Zero mask: done only
        base_r = result_cnt; base_d = done_cnt;
        do_start(4'b0000, 3'd0, 3'd4);
        wait_for("t6_done", 1, base_d + 1, 20);
        check("t6_done_latency", 64'(done_cyc - start_edge), 64'd0);
        repeat (5) @(negedge clk);
        check("t6_no_result", 64'(result_cnt - base_r), 64'd0);

        // avg_log2 above the maximum is clamped to 16 samples
        base_r = result_cnt; base_rd = read_cnt;
        for (int i = 0; i < 16; i++) push_adc(2, 16'(100 + i));
        push_exp(2'd3, 16'd107, 1'b0);
        do_start(4'b1000, 3'd7, 3'd2);
        wait_for("t7_result", 0, base_r + 1, 400);
        check("t7_reads", 64'(read_cnt - base_rd), 64'd16);
        repeat (5) @(negedge clk);

        // abort and start together in IDLE: nothing starts
        @(posedge clk); #1;
        channel_mask = 4'b0001; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("t9_abort_over_start", 64'(busy), 64'd0);

        // Synchronous reset in the middle of WAIT
        base_d = done_cnt; base_rd = read_cnt;
        push_adc(-1, 16'h0);
        do_start(4'b0001, 3'd0, 3'd6);
        wait_for("t8_read", 2, base_rd + 1, 100);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t8_rst_outputs", outs_no_cfg(), 64'd0);
        check("t8_rst_config", 64'(sens_config), 64'd0);
        adc_q.delete(); flush_req++;
        repeat (10) @(negedge clk);
        check("t8_no_done", 64'(done_cnt - base_d), 64'd0);
        check("t8_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
